// File: rtl/melody_sequencer.sv
// Score-RAM driven note sequencer feeding a note/octave tone divider.
// Optional MELODY_SEQ_LOOP_EN adds a loop input that restarts the tune instead of completing.
module melody_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int TICK_DIV  = 3125000,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              start,
  input  logic              stop,
`ifdef MELODY_SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [3:0]        note,
  output logic [2:0]        octave,
  output logic              tone_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, GAP} state_t;

  localparam int                PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]        GAP_LOAD   = 7'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  state_t        state, state_n;
  logic [15:0]   ram [2**ADDR_W];
  logic [15:0]   rd_data;
  logic [PW-1:0] presc;
  logic [6:0]    dur_cnt;
  logic          rest_q;

  logic tick, last_tick, step, end_seq, adv, clr_addr;
  logic load_entry, load_gap, done_n, tone_n, loop_sel;

`ifdef MELODY_SEQ_LOOP_EN
  assign loop_sel = loop;
`else
  assign loop_sel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    step       = 1'b0;
    end_seq    = 1'b0;
    adv        = 1'b0;
    clr_addr   = 1'b0;
    load_entry = 1'b0;
    load_gap   = 1'b0;
    done_n     = 1'b0;
    tick       = (presc == PRESC_LAST);
    last_tick  = tick && (dur_cnt == 7'd1);
    unique case (state)
      IDLE:   if (start) begin state_n = FETCH; clr_addr = 1'b1; end
      FETCH:  state_n = DECODE;
      DECODE: begin
        if (rd_data[15])              end_seq = 1'b1;
        else if (rd_data[6:0] == '0)  step = 1'b1;
        else begin load_entry = 1'b1; state_n = PLAY; end
      end
      PLAY: if (last_tick) begin
        if (GAP_TICKS == 0) step = 1'b1;
        else begin load_gap = 1'b1; state_n = GAP; end
      end
      GAP:     if (last_tick) step = 1'b1;
      default: state_n = IDLE;
    endcase
    // Stepping past the last address is treated like an end marker.
    if (step) begin
      if (cur_addr == LAST_ADDR) end_seq = 1'b1;
      else begin adv = 1'b1; state_n = FETCH; end
    end
    if (end_seq) begin
      if (loop_sel) begin clr_addr = 1'b1; state_n = FETCH; end
      else begin done_n = 1'b1; state_n = IDLE; end
    end
    if (stop) begin
      state_n    = IDLE;
      done_n     = 1'b0;
      adv        = 1'b0;
      clr_addr   = 1'b0;
      load_entry = 1'b0;
      load_gap   = 1'b0;
    end
    // Rest bit comes straight from the RAM word on the cycle PLAY is entered.
    tone_n = (state_n == PLAY) && (load_entry ? !rd_data[14] : !rest_q);
  end

  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note     <= '0;
      octave   <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_addr <= '0;
      rd_data  <= '0;
      presc    <= '0;
      dur_cnt  <= '0;
      rest_q   <= 1'b0;
    end else begin
      busy    <= (state_n != IDLE);
      done    <= done_n;
      tone_en <= tone_n;
      if (state == FETCH) rd_data <= ram[cur_addr];
      if (clr_addr)  cur_addr <= '0;
      else if (adv)  cur_addr <= cur_addr + 1'b1;
      if (load_entry) begin
        note    <= rd_data[10:7];
        octave  <= rd_data[13:11];
        rest_q  <= rd_data[14];
        dur_cnt <= rd_data[6:0];
        presc   <= '0;
      end else if (load_gap) begin
        dur_cnt <= GAP_LOAD;
        presc   <= '0;
      end else if (state == PLAY || state == GAP) begin
        if (tick) begin
          presc   <= '0;
          dur_cnt <= dur_cnt - 7'd1;
        end else begin
          presc   <= presc + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer (TICK_DIV=4, GAP_TICKS=1, 16-entry score).
module tb_melody_sequencer;
  localparam int ADDR_W    = 4;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;

  logic              clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [15:0]       wr_data = '0;
  logic [3:0]        note;
  logic [2:0]        octave;
  logic              tone_en, busy, done;
  logic [ADDR_W-1:0] cur_addr;
`ifdef MELODY_SEQ_LOOP_EN
  logic              loop = 1'b0;
`endif

  int checks = 0, errors = 0, k = 0;

  melody_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop),
`ifdef MELODY_SEQ_LOOP_EN
    .loop(loop),
`endif
    .note(note), .octave(octave), .tone_en(tone_en), .busy(busy), .done(done),
    .cur_addr(cur_addr));

  always #5 clk = ~clk;

  // k counts edges since start was raised; samples are taken 1 time unit after each edge.
  task automatic step();
    @(posedge clk); #1; k++;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse();
    k = 0; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({note, octave, tone_en, busy, done, cur_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got note=%0d oct=%0d tone=%b busy=%b done=%b addr=%0d exp all 0",
               note, octave, tone_en, busy, done, cur_addr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic et, ed, eb;
    wr(0, 16'h1182); wr(1, 16'h8000);
    pulse();
    while (k <= 20) begin
      et = (k >= 3 && k <= 10); ed = (k == 17); eb = (k >= 1 && k <= 16);
      checks++;
      if (tone_en !== et || done !== ed || busy !== eb) begin
        errors++;
        $display("FAIL basic_ctl k=%0d got tone=%b done=%b busy=%b exp tone=%b done=%b busy=%b",
                 k, tone_en, done, busy, et, ed, eb);
      end
      if (k == 3) begin
        checks++;
        if (note !== 4'd3 || octave !== 3'd2) begin
          errors++;
          $display("FAIL basic_note got note=%0d oct=%0d exp note=3 oct=2", note, octave);
        end
      end
      if (k == 15) begin
        checks++;
        if (cur_addr !== 4'd1) begin
          errors++; $display("FAIL basic_addr got %0d exp 1", cur_addr);
        end
      end
      step();
    end
  endtask

  task automatic test_rest();
    logic et, ed;
    logic [ADDR_W-1:0] ea;
    wr(0, 16'h4003); wr(1, 16'h0B81); wr(2, 16'h8000);
    pulse();
    while (k <= 32) begin
      et = (k >= 21 && k <= 24); ed = (k == 31);
      ea = (k < 19) ? 4'd0 : (k < 29) ? 4'd1 : 4'd2;
      checks++;
      if (tone_en !== et || done !== ed || cur_addr !== ea) begin
        errors++;
        $display("FAIL rest_seq k=%0d got tone=%b done=%b addr=%0d exp tone=%b done=%b addr=%0d",
                 k, tone_en, done, cur_addr, et, ed, ea);
      end
      if (k == 21) begin
        checks++;
        if (note !== 4'd7 || octave !== 3'd1) begin
          errors++; $display("FAIL rest_note got note=%0d oct=%0d exp note=7 oct=1", note, octave);
        end
      end
      step();
    end
  endtask

  task automatic test_skip();
    logic et, ed;
    wr(0, 16'h0480); wr(1, 16'h0281); wr(2, 16'h8000);
    pulse();
    while (k <= 16) begin
      et = (k >= 5 && k <= 8); ed = (k == 15);
      checks++;
      if (tone_en !== et || done !== ed) begin
        errors++;
        $display("FAIL skip_seq k=%0d got tone=%b done=%b exp tone=%b done=%b", k, tone_en, done, et, ed);
      end
      if (k == 5) begin
        checks++;
        if (note !== 4'd5) begin errors++; $display("FAIL skip_note got %0d exp 5", note); end
      end
      step();
    end
  endtask

  task automatic test_stop();
    logic saw_done;
    wr(0, 16'h1904); wr(1, 16'h8000);
    pulse();
    step();
    wr_addr = 4'd0; wr_data = 16'h2D81; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++;
    if (tone_en !== 1'b1 || note !== 4'd2 || octave !== 3'd3) begin
      errors++;
      $display("FAIL stop_play got tone=%b note=%0d oct=%0d exp tone=1 note=2 oct=3", tone_en, note, octave);
    end
    while (k < 6) step();
    stop = 1'b1;
    step();
    checks++;
    if (tone_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cur_addr !== 4'd0) begin
      errors++;
      $display("FAIL stop_resp got tone=%b busy=%b done=%b addr=%0d exp 0 0 0 0", tone_en, busy, done, cur_addr);
    end
    stop = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin step(); saw_done |= done; end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL stop_nodone got done pulse exp none"); end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_wins got busy=%b exp 0", busy); end
    // Replay address 0: the write attempted while busy must not have landed.
    pulse();
    step(); step();
    checks++;
    if (tone_en !== 1'b1 || note !== 4'd2 || octave !== 3'd3) begin
      errors++;
      $display("FAIL stop_ramkeep got tone=%b note=%0d oct=%0d exp tone=1 note=2 oct=3", tone_en, note, octave);
    end
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(((i % 12) << 7) | 1));
`ifdef MELODY_SEQ_LOOP_EN
    loop = 1'b1;
`endif
    pulse();
    while (k <= 163) begin
      if (k == 152 || k == 153) begin
        checks++;
        if (tone_en !== (k == 153) || cur_addr !== 4'd15) begin
          errors++;
          $display("FAIL wrap_last k=%0d got tone=%b addr=%0d exp tone=%b addr=15", k, tone_en, cur_addr, (k == 153));
        end
      end
      if (k == 153) begin
        checks++;
        if (note !== 4'd3) begin errors++; $display("FAIL wrap_note got %0d exp 3", note); end
      end
      if (k == 160 || k == 161) begin
        checks++;
`ifdef MELODY_SEQ_LOOP_EN
        if (done !== 1'b0 || busy !== 1'b1 || cur_addr !== ((k == 161) ? 4'd0 : 4'd15)) begin
          errors++;
          $display("FAIL wrap_loop k=%0d got done=%b busy=%b addr=%0d", k, done, busy, cur_addr);
        end
`else
        if (done !== (k == 161) || busy !== (k == 160) || cur_addr !== 4'd15) begin
          errors++;
          $display("FAIL wrap_end k=%0d got done=%b busy=%b addr=%0d exp done=%b busy=%b addr=15",
                   k, done, busy, cur_addr, (k == 161), (k == 160));
        end
`endif
      end
      step();
    end
`ifdef MELODY_SEQ_LOOP_EN
    loop = 1'b0;
    stop = 1'b1; step(); stop = 1'b0; step();
`endif
  endtask

  task automatic test_reset_mid();
    wr(0, 16'h1182); wr(1, 16'h8000);
    pulse();
    while (k < 5) step();
    checks++;
    if (tone_en !== 1'b1) begin errors++; $display("FAIL rmid_pre got tone=%b exp 1", tone_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tone_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_async got tone=%b busy=%b exp 0 0", tone_en, busy);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    step();
    checks++;
    if ({note, octave, tone_en, busy, done, cur_addr} !== '0) begin
      errors++;
      $display("FAIL rmid_outs got note=%0d oct=%0d tone=%b busy=%b done=%b addr=%0d exp all 0",
               note, octave, tone_en, busy, done, cur_addr);
    end
    pulse();
    step(); step();
    checks++;
    if (tone_en !== 1'b1 || note !== 4'd3 || octave !== 3'd2) begin
      errors++;
      $display("FAIL rmid_restart got tone=%b note=%0d oct=%0d exp tone=1 note=3 oct=2", tone_en, note, octave);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rest();
    test_skip();
    test_stop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
